// File: rtl/pc_fetch_pkg.sv
// Shared processor package: fetch FSM states, reset PC and instruction width,
// plus the record carried through the fetch buffer.
package pc_fetch_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        BOOT,
        FETCH
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry buffer between instruction memory and decode. Push and pop may
// happen together at any occupancy; flush wins over both.
module fetch_fifo2
    import pc_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[gi] <= '0;
            end else if (push && !flush && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= push_data;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch: PC register, one-cycle-latency memory request, and a
// two-entry buffer toward decode with redirect squashing.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect,
    input  logic [31:0]        target,
    output logic [31:0]        pc_plus4,
    output logic               imem_en,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         inflight_q, inflight_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;

    logic         fifo_push, fifo_pop;
    logic [1:0]   fifo_count;
    logic [2:0]   occupancy;
    fetch_entry_t fifo_head;
    fetch_entry_t push_entry;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        out_valid = (fifo_count != 2'd0) && !redirect;
        fifo_pop  = out_valid && out_ready;
        // Slots that will be taken next cycle if nothing new is requested.
        occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, fifo_pop};
        imem_en   = 1'b0;
        // A response landing during a redirect belongs to the old path.
        fifo_push = inflight_q && !redirect;

        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                imem_en = !redirect && (occupancy < 3'd2);
            end
            default: state_d = BOOT;
        endcase

        if (redirect) begin
            pc_d = target & 32'hFFFF_FFFC;
        end else if (imem_en) begin
            pc_d          = pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_entry = '{pc: inflight_pc_q, instr: imem_rdata};

    fetch_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect),
        .push_data (push_entry),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign pc_plus4  = pc_q + 32'd4;
    assign imem_addr = pc_q & 32'hFFFF_FFFC;
    assign out_instr = fifo_head.instr;
    assign out_pc    = fifo_head.pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: per-cycle vector table plus delivery scoreboard, and a
// short hand-written sequence for the wrapping reset PC instance.
module tb_pc_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect, out_ready;
    logic [31:0] target, imem_rdata, pc_plus4, imem_addr, out_instr, out_pc;
    logic        imem_en, out_valid;

    logic        w_redirect, w_out_ready;
    logic [31:0] w_target, w_imem_rdata, w_pc_plus4, w_imem_addr, w_out_instr, w_out_pc;
    logic        w_imem_en, w_out_valid;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .target(target),
        .pc_plus4(pc_plus4), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .redirect(w_redirect), .target(w_target),
        .pc_plus4(w_pc_plus4), .imem_en(w_imem_en), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc)
    );

    // Instruction memories with one-cycle registered read; junk when idle.
    always @(posedge clk) begin
        imem_rdata   <= imem_en   ? instr_of(imem_addr)   : 32'hBAD0_BAD0;
        w_imem_rdata <= w_imem_en ? instr_of(w_imem_addr) : 32'hBAD0_BAD0;
    end

    typedef struct {
        logic        rst_n;
        logic        redirect;
        logic [31:0] target;
        logic        rdy;
        logic        en;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] t,
                                input logic rdy, input logic en, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t x;
        x.rst_n = r; x.redirect = rd; x.target = t; x.rdy = rdy;
        x.en = en; x.addr = a; x.valid = v; x.pc = p;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected deliveries are queued at request time and retired on pop.
    task automatic sb_step();
        logic [31:0] a;
        if (!rst_n || redirect) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_pop: got pc %h expected none", out_pc);
                end else begin
                    a = sb_q.pop_front();
                    chk("sb_pc", out_pc, a);
                    chk("sb_instr", out_instr, instr_of(a));
                    $display("deliver pc=%h instr=%h", out_pc, out_instr);
                end
            end
            if (imem_en) sb_q.push_back(imem_addr);
            checks++;
            if (sb_q.size() > 2) begin
                errors++;
                $display("FAIL sb_occupancy: got %0d expected <=2", sb_q.size());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; target = '0; out_ready = 1'b1;
        w_redirect = 1'b0; w_target = '0; w_out_ready = 1'b1;

        // reset then streaming
        tbl.push_back(mk(0,0,0,1, 0,0,       0,0));
        tbl.push_back(mk(1,0,0,1, 0,0,       0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h0,   0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h4,   0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h8,   1,32'h0));
        tbl.push_back(mk(1,0,0,1, 1,32'hC,   1,32'h4));
        // stall from boot, then release
        tbl.push_back(mk(0,0,0,1, 0,0,       0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,       0,0));
        tbl.push_back(mk(1,0,0,0, 1,32'h0,   0,0));
        tbl.push_back(mk(1,0,0,0, 1,32'h4,   0,0));
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'h0));
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'h0));
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'h0));
        tbl.push_back(mk(1,0,0,1, 1,32'h8,   1,32'h0));
        tbl.push_back(mk(1,0,0,1, 1,32'hC,   1,32'h4));
        tbl.push_back(mk(1,0,0,1, 1,32'h10,  1,32'h8));
        // fill, then redirect with two entries buffered
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'hC));
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'hC));
        tbl.push_back(mk(1,1,32'h103,1, 0,0, 0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h100, 0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h104, 0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h108, 1,32'h100));
        // redirect held two cycles while stalled
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'h104));
        tbl.push_back(mk(1,1,32'h200,0, 0,0, 0,0));
        tbl.push_back(mk(1,1,32'h300,0, 0,0, 0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h300, 0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h304, 0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h308, 1,32'h300));
        // reset during a stalled full buffer
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'h304));
        tbl.push_back(mk(1,0,0,0, 0,0,       1,32'h304));
        tbl.push_back(mk(0,0,0,0, 0,0,       0,0));
        tbl.push_back(mk(1,0,0,1, 0,0,       0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h0,   0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h4,   0,0));
        tbl.push_back(mk(1,0,0,1, 1,32'h8,   1,32'h0));

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rst_n     = tbl[i].rst_n;
            redirect  = tbl[i].redirect;
            target    = tbl[i].target;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("row%0d_imem_en", i), imem_en, tbl[i].en);
            if (tbl[i].en) begin
                chk($sformatf("row%0d_imem_addr", i), imem_addr, tbl[i].addr);
                chk($sformatf("row%0d_pc_plus4", i), pc_plus4, tbl[i].addr + 32'd4);
            end
            chk($sformatf("row%0d_out_valid", i), out_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                chk($sformatf("row%0d_out_pc", i), out_pc, tbl[i].pc);
                chk($sformatf("row%0d_out_instr", i), out_instr, instr_of(tbl[i].pc));
            end
            if (!tbl[i].rst_n) begin
                chk($sformatf("row%0d_rst_out_pc", i), out_pc, 32'h0);
                chk($sformatf("row%0d_rst_out_instr", i), out_instr, 32'h0);
                chk($sformatf("row%0d_rst_pc_plus4", i), pc_plus4, 32'h4);
            end
            sb_step();
        end

        // wrapping reset PC on the second instance
        @(posedge clk); #1; rst_n = 1'b0; redirect = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("wrap_rst_pc_plus4", w_pc_plus4, 32'h0);
        chk("wrap_rst_valid", w_out_valid, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("wrap_boot_en", w_imem_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_req0_en", w_imem_en, 1'b1);
        chk("wrap_req0_addr", w_imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req0_pc_plus4", w_pc_plus4, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_req1_en", w_imem_en, 1'b1);
        chk("wrap_req1_addr", w_imem_addr, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wrap_out_valid", w_out_valid, 1'b1);
        chk("wrap_out_pc", w_out_pc, 32'hFFFF_FFFC);
        chk("wrap_out_instr", w_out_instr, instr_of(32'hFFFF_FFFC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port redirect  input  1  taken branch/jump; load target into PC.
REQ-006 SHALL have port target  input  32  redirect address, from the 32-bit 2:1 next-PC select stage.
REQ-007 SHALL have port pc_plus4  output  32  current PC + 4, feeding the next-PC select stage.
REQ-008 SHALL have port imem_en  output  1  instruction-memory read request.
REQ-009 SHALL have port imem_addr  output  32  instruction-memory word address, bits [1:0] always 0.
REQ-010 SHALL have port imem_rdata  input  32  read data, valid exactly one cycle after imem_en.
REQ-011 SHALL have port out_valid  output  1  instruction available to decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts the instruction.
REQ-013 SHALL have port out_instr  output  32  fetched instruction.
REQ-014 SHALL have port out_pc  output  32  address of out_instr.

Function
REQ-015 SHALL implement FSM states BOOT and FETCH: BOOT lasts exactly one cycle after reset release with imem_en=0, then moves to FETCH unconditionally.
REQ-016 SHALL hold PC in a 32-bit register; pc_plus4 = PC+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-017 SHALL, in FETCH, assert imem_en iff redirect=0 and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready.
REQ-018 SHALL drive imem_addr = PC whenever imem_en=1; on that edge PC <= PC+4, inflight <= 1, inflight_pc <= PC.
REQ-019 SHALL, in a cycle with inflight=1, push {inflight_pc, imem_rdata} into a 2-entry FIFO and clear inflight unless a new request is issued that cycle.
REQ-020 SHALL drive out_valid = FIFO non-empty; out_instr/out_pc = FIFO head; pop on out_valid & out_ready.
REQ-021 SHALL support simultaneous push and pop at any occupancy, including full.
REQ-022 SHALL sustain one instruction per cycle while out_ready=1.
REQ-023 SHALL, on redirect=1: force out_valid=0 that cycle, empty the FIFO, discard any in-flight response, and set PC <= {target[31:2], 2'b00}.
REQ-024 SHALL give redirect priority over stall (out_ready=0) and over pop in the same cycle.
REQ-025 SHALL, with redirect held for N cycles, issue no request during those cycles and resume fetching at the last target one cycle after redirect drops.
REQ-026 SHALL keep out_instr/out_pc stable while out_valid=1 and out_ready=0.
REQ-027 SHALL never overflow the FIFO and never drop a non-squashed response.

Reset
REQ-028 SHALL, while rst_n=0, set PC=RESET_PC, state=BOOT, FIFO empty, inflight=0, imem_en=0, out_valid=0, out_instr=0, out_pc=0, pc_plus4=RESET_PC+4.
REQ-029 SHALL treat reset asserted mid-operation identically, discarding all buffered and in-flight instructions.

Structure
REQ-030 SHALL place the FSM state enumeration, the reset PC constant and the instruction width (32) in the shared processor package.
REQ-031 SHALL implement the 2-entry buffer as one sub-module, fetch_fifo2, with push/pop/flush, count and head outputs.

Verification
REQ-032 SHALL verify reset: release rst_n, out_ready=1 -> imem_en=0 for the first cycle, requests to 0x0, 0x4, 0x8 on consecutive cycles, out_pc=0x0 two cycles after the first request.
REQ-033 SHALL verify stall: out_ready=0 for 5 cycles -> at most 2 instructions buffered, imem_en=0 while full, out_pc held at 0x0; on release, 0x0, 0x4, 0x8 delivered in order without loss.
REQ-034 SHALL verify redirect: redirect=1, target=0x0000_0103 while the FIFO holds 2 entries -> out_valid=0 that cycle, next request to 0x100, stale entries never delivered.
REQ-035 SHALL verify redirect with stall: redirect=1 and out_ready=0 in the same cycle -> redirect taken, FIFO flushed.
REQ-036 SHALL verify wrap: RESET_PC=0xFFFF_FFFC -> requests to 0xFFFF_FFFC then 0x0000_0000.
REQ-037 SHALL verify mid-run reset: rst_n=0 during a stalled full FIFO -> out_valid=0 immediately, and after release fetch restarts at RESET_PC.
